// File: rtl/gate_truth_checker.sv
// Built-in self-test sequencer for the two-input gate block: walks {a,b} through
// 00..11, compares the seven gate outputs to their truth table and records errors.
module gate_truth_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 a,
  output logic                 b,
  input  logic                 and_in,
  input  logic                 or_in,
  input  logic                 not_in,
  input  logic                 nand_in,
  input  logic                 nor_in,
  input  logic                 xor_in,
  input  logic                 xnor_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [6:0]           err_mask,
  output logic [3:0]           err_vec,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LD  = 4'(SETTLE_CYCLES);
  localparam bit         HAS_SETTLE = (SETTLE_CYCLES > 0);

  // Bit order matches err_mask: {xnor, xor, nor, nand, not, or, and}.
  function automatic logic [6:0] gate_expect(input logic ia, input logic ib);
    return {~(ia ^ ib), ia ^ ib, ~(ia | ib), ~(ia & ib), ~ia, ia | ib, ia & ib};
  endfunction

  state_t               state_q;
  logic [1:0]           idx_q;
  logic [3:0]           cnt_q;
  logic                 a_q, b_q, busy_q, done_q, pass_q;
  logic [6:0]           err_mask_q;
  logic [3:0]           err_vec_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  logic [6:0]           mismatch_d;
  logic [1:0]           idx_d;
  logic [ERR_CNT_W-1:0] err_count_d;

  // Gate comparison against the registered stimulus, next index and saturating count.
  always_comb begin
    mismatch_d  = 7'd0;
    idx_d       = idx_q + 2'd1;
    err_count_d = err_count_q;
    mismatch_d  = {xnor_in, xor_in, nor_in, nand_in, not_in, or_in, and_in}
                  ^ gate_expect(a_q, b_q);
    if (&err_count_q) begin
      err_count_d = err_count_q;
    end else begin
      err_count_d = err_count_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Test sequencer: stimulus generation, sampling and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= 4'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_mask_q  <= 7'd0;
      err_vec_q   <= 4'd0;
      err_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            idx_q      <= 2'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b1;
            pass_q     <= 1'b0;
            err_mask_q <= 7'd0;
            err_vec_q  <= 4'd0;
            cnt_q      <= SETTLE_LD;
            state_q    <= HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
          end
        end
        ST_SETTLE: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          err_mask_q <= err_mask_q | mismatch_d;
          if (|mismatch_d) begin
            err_vec_q[idx_q] <= 1'b1;
            err_count_q      <= err_count_d;
          end
          if (idx_q != 2'd3) begin
            idx_q   <= idx_d;
            a_q     <= idx_d[1];
            b_q     <= idx_d[0];
            cnt_q   <= SETTLE_LD;
            state_q <= HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
          end else begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          pass_q  <= (err_mask_q == 7'd0);
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_mask  = err_mask_q;
  assign err_vec   = err_vec_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Randomized self-checking bench: a fault-injectable gate block feeds the checker,
// and a per-vector fault table predicts every status output.
module tb_gate_truth_checker;

  localparam int S1  = 1;
  localparam int PER = S1 + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       a, b, busy, done, pass;
  logic       and_in, or_in, not_in, nand_in, nor_in, xor_in, xnor_in;
  logic [6:0] err_mask;
  logic [3:0] err_vec;
  logic [7:0] err_count;

  logic       start2 = 1'b0;
  logic       a2, b2, busy2, done2, pass2;
  logic [6:0] err_mask2;
  logic [3:0] err_vec2;
  logic [1:0] err_count2;

  logic [6:0] flips [4];
  int         errors = 0;
  int         checks = 0;
  int         m_count = 0;

  always #5 clk = ~clk;

  // Truth table from integer arithmetic, bit order {xnor,xor,nor,nand,not,or,and}.
  function automatic logic [6:0] truth(input int v);
    int x, y;
    x = v / 2;
    y = v % 2;
    truth[0] = (x * y == 1);
    truth[1] = (x + y > 0);
    truth[2] = (x == 0);
    truth[3] = (x * y == 0);
    truth[4] = (x + y == 0);
    truth[5] = (x + y == 1);
    truth[6] = (x + y != 1);
  endfunction

  always_comb begin
    {xnor_in, xor_in, nor_in, nand_in, not_in, or_in, and_in} =
      truth(int'({a, b})) ^ flips[{a, b}];
  end

  gate_truth_checker #(.SETTLE_CYCLES(S1), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .and_in(and_in), .or_in(or_in), .not_in(not_in), .nand_in(nand_in),
    .nor_in(nor_in), .xor_in(xor_in), .xnor_in(xnor_in),
    .busy(busy), .done(done), .pass(pass),
    .err_mask(err_mask), .err_vec(err_vec), .err_count(err_count)
  );

  // Second instance: zero settle, 2-bit counter, every gate output stuck at 0.
  gate_truth_checker #(.SETTLE_CYCLES(0), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .and_in(1'b0), .or_in(1'b0), .not_in(1'b0), .nand_in(1'b0),
    .nor_in(1'b0), .xor_in(1'b0), .xnor_in(1'b0),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_mask(err_mask2), .err_vec(err_vec2), .err_count(err_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_flips(input logic [6:0] f0, input logic [6:0] f1,
                           input logic [6:0] f2, input logic [6:0] f3);
    flips[0] = f0; flips[1] = f1; flips[2] = f2; flips[3] = f3;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    m_count = 0;
  endtask

  // One full run on dut; optionally re-pulses start mid-run and during DONE.
  task automatic run1(input bit repulse);
    logic [6:0] exp_mask;
    logic [3:0] exp_vec;
    exp_mask = 7'd0;
    exp_vec  = 4'd0;
    for (int v = 0; v < 4; v++) begin
      if (flips[v] != 7'd0) begin
        exp_vec[v] = 1'b1;
        exp_mask   = exp_mask | flips[v];
        if (m_count < 255) m_count++;
      end
    end
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 4 * PER; k++) begin
      @(negedge clk);
      start = repulse && (k == 2 || k == 4 * PER);
      chk("busy_run", busy, 1);
      chk("done_run", done, k == 4 * PER);
      chk("ab_seq", {a, b}, (k < 4 * PER) ? k / PER : 3);
    end
    @(negedge clk) start = 1'b0;
    chk("busy_end", busy, 0);
    chk("done_end", done, 0);
    chk("pass", pass, exp_mask == 7'd0);
    chk("err_mask", err_mask, exp_mask);
    chk("err_vec", err_vec, exp_vec);
    chk("err_count", err_count, m_count);
    @(negedge clk);
    chk("no_restart", busy, 0);
  endtask

  initial begin
    set_flips(7'd0, 7'd0, 7'd0, 7'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_ab", {a, b}, 0);
    chk("rst_flags", {done, pass, err_mask, err_vec}, 0);
    chk("rst_count", err_count, 0);

    // Clean gate block.
    run1(1'b0);
    // xor stuck at 0.
    set_flips(7'd0, 7'b0100000, 7'b0100000, 7'd0);
    run1(1'b0);
    // not driven from b instead of a, two runs after a reset.
    do_reset();
    set_flips(7'd0, 7'b0000100, 7'b0000100, 7'd0);
    run1(1'b0);
    run1(1'b0);

    // Reset in the third busy cycle aborts the run.
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      rst = (k == 2);
    end
    @(negedge clk) rst = 1'b0;
    m_count = 0;
    chk("abort_busy", busy, 0);
    chk("abort_ab", {a, b}, 0);
    chk("abort_flags", {err_mask, err_vec}, 0);
    chk("abort_count", err_count, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("abort_nodone", {done, busy}, 0);
    end

    // start re-pulsed while busy and during DONE.
    set_flips(7'd0, 7'd0, 7'b0000001, 7'd0);
    run1(1'b1);

    // Randomized fault tables.
    for (int r = 0; r < 24; r++) begin
      for (int v = 0; v < 4; v++) begin
        flips[v] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
      end
      run1($urandom_range(0, 1) == 1);
    end

    // Zero-settle, saturating 2-bit counter, all outputs stuck at 0.
    for (int r = 0; r < 2; r++) begin
      @(negedge clk) start2 = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        start2 = 1'b0;
        chk("s0_busy", busy2, 1);
        chk("s0_done", done2, k == 4);
        chk("s0_ab", {a2, b2}, (k < 4) ? k : 3);
      end
      @(negedge clk);
      chk("s0_busy_end", busy2, 0);
    end
    chk("s0_count", err_count2, 3);
    chk("s0_mask", err_mask2, 7'b1111111);
    chk("s0_vec", err_vec2, 4'b1111);
    chk("s0_pass", pass2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
